// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter/mux.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      TURN = 2'd2
   } state_e;

   localparam int unsigned MAX_TURN_CYCLES = 15;
   localparam int unsigned TURN_W          = 4;

   // Channel index width; at least one bit even for degenerate counts.
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request after ptr, with wrap.
module rr_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   localparam int unsigned IDX_W = ch_idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_CH-1:0] gnt_oh_c,
   output logic [IDX_W-1:0]  idx_c,
   output logic              any_c
);

   localparam int unsigned CW = IDX_W + 1;

   logic [CW-1:0] cand;
   logic          found;

   // ptr + i never exceeds 2*NUM_CH-1, so one conditional subtract wraps it.
   always_comb begin
      gnt_oh_c = '0;
      idx_c    = '0;
      found    = 1'b0;
      cand     = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         cand = CW'(ptr) + CW'(i);
         if (cand >= CW'(NUM_CH)) cand = cand - CW'(NUM_CH);
         if (!found && req[cand[IDX_W-1:0]]) begin
            found                      = 1'b1;
            gnt_oh_c[cand[IDX_W-1:0]]  = 1'b1;
            idx_c                      = cand[IDX_W-1:0];
         end
      end
      any_c = found;
   end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered round-robin bus arbiter and data mux with optional turnaround
// cycles between owners and active-low request/grant handshake.
module bus_arbiter_mux
   import bus_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned TURN_CYCLES  = 1,
   parameter bit          HOLD_ON_IDLE = 1'b1
) (
   input  logic                    CLK,
   input  logic                    N_RST,
   input  logic [NUM_CH*WIDTH-1:0] IN,
   input  logic [NUM_CH-1:0]       N_REQ,
   input  logic                    LOCK,
   output logic [NUM_CH-1:0]       N_GNT,
   output logic [WIDTH-1:0]        OUT,
   output logic                    VALID
);

   localparam int unsigned IDX_W = ch_idx_w(NUM_CH);

   state_e              state_q, state_d;
   logic [TURN_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [NUM_CH-1:0]   n_gnt_d;
   logic [WIDTH-1:0]    out_d;
   logic                valid_d;

   logic [NUM_CH-1:0]   req_c;
   logic [NUM_CH-1:0]   win_oh_c;
   logic [IDX_W-1:0]    win_idx_c;
   logic                any_req_c;
   logic                arb_c;

   assign req_c = ~N_REQ;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
      .req      (req_c),
      .ptr      (ptr_q),
      .gnt_oh_c (win_oh_c),
      .idx_c    (win_idx_c),
      .any_c    (any_req_c)
   );

   // State, counter, pointer and all outputs are flops.
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= IDX_W'(NUM_CH - 1);
         N_GNT   <= '1;
         OUT     <= '0;
         VALID   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         N_GNT   <= n_gnt_d;
         OUT     <= out_d;
         VALID   <= valid_d;
      end
   end

   // Next state; ptr_q doubles as the owner index while in OWN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      n_gnt_d = N_GNT;
      arb_c   = 1'b0;
      case (state_q)
         IDLE: arb_c = 1'b1;
         OWN: begin
            if (!req_c[ptr_q] && !LOCK) begin
               if (TURN_CYCLES > 0) begin
                  state_d = TURN;
                  cnt_d   = TURN_W'(TURN_CYCLES);
                  n_gnt_d = '1;
               end else begin
                  arb_c = 1'b1;
               end
            end
         end
         TURN: begin
            cnt_d = cnt_q - TURN_W'(1);
            if (cnt_q == TURN_W'(1)) arb_c = 1'b1;
         end
         default: begin
            state_d = IDLE;
            n_gnt_d = '1;
         end
      endcase
      if (arb_c) begin
         if (any_req_c) begin
            state_d = OWN;
            ptr_d   = win_idx_c;
            n_gnt_d = ~win_oh_c;
         end else begin
            state_d = IDLE;
            n_gnt_d = '1;
         end
      end
   end

   // Data path: capture the owner's slice on every OWN edge, release included.
   always_comb begin
      out_d   = HOLD_ON_IDLE ? OUT : '0;
      valid_d = 1'b0;
      if (state_q == OWN) begin
         valid_d = 1'b1;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ptr_q == IDX_W'(c)) out_d = IN[c*WIDTH +: WIDTH];
         end
      end
   end

`ifdef FORMAL
   always_ff @(posedge CLK) begin
      if (N_RST) assert ($onehot0(~N_GNT));
   end
`endif

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed scoreboard bench: three builds (default, HOLD_ON_IDLE=0, TURN_CYCLES=0) share stimulus.
module tb_bus_arbiter_mux;

   localparam logic [31:0] D0 = 32'h0000_0A0A;
   localparam logic [31:0] D1 = 32'h1111_1111;
   localparam logic [31:0] D2 = 32'hDEAD_BEEF;
   localparam logic [31:0] D3 = 32'h3333_3333;

   logic         clk = 1'b0;
   logic         n_rst;
   logic [127:0] in_bus;
   logic [3:0]   n_req;
   logic         lock;

   logic [3:0]  gnt_a, gnt_b, gnt_c;
   logic [31:0] out_a, out_b, out_c;
   logic        val_a, val_b, val_c;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      int          dut;
      logic [3:0]  n_gnt;
      logic [31:0] out;
      logic        valid;
   } exp_t;

   exp_t sbq[$];
   logic [31:0] dv [4];

   always #5 clk = ~clk;

   bus_arbiter_mux #(.WIDTH(32), .NUM_CH(4), .TURN_CYCLES(1), .HOLD_ON_IDLE(1'b1)) u_main (
      .CLK(clk), .N_RST(n_rst), .IN(in_bus), .N_REQ(n_req), .LOCK(lock),
      .N_GNT(gnt_a), .OUT(out_a), .VALID(val_a));

   bus_arbiter_mux #(.WIDTH(32), .NUM_CH(4), .TURN_CYCLES(1), .HOLD_ON_IDLE(1'b0)) u_hold0 (
      .CLK(clk), .N_RST(n_rst), .IN(in_bus), .N_REQ(n_req), .LOCK(lock),
      .N_GNT(gnt_b), .OUT(out_b), .VALID(val_b));

   bus_arbiter_mux #(.WIDTH(32), .NUM_CH(4), .TURN_CYCLES(0), .HOLD_ON_IDLE(1'b1)) u_tc0 (
      .CLK(clk), .N_RST(n_rst), .IN(in_bus), .N_REQ(n_req), .LOCK(lock),
      .N_GNT(gnt_c), .OUT(out_c), .VALID(val_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic push(input string tag, input int dut, input logic [3:0] g,
                       input logic [31:0] o, input logic v);
      exp_t e;
      e.tag = tag; e.dut = dut; e.n_gnt = g; e.out = o; e.valid = v;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [3:0]  g;
      logic [31:0] o;
      logic        v;
      while (sbq.size() != 0) begin
         e = sbq.pop_front();
         case (e.dut)
            0:       begin g = gnt_a; o = out_a; v = val_a; end
            1:       begin g = gnt_b; o = out_b; v = val_b; end
            default: begin g = gnt_c; o = out_c; v = val_c; end
         endcase
         chk({e.tag, ".n_gnt"}, 32'(g), 32'(e.n_gnt));
         chk({e.tag, ".out"},   o,      e.out);
         chk({e.tag, ".valid"}, 32'(v), 32'(e.valid));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      logic [3:0] ng;
      int         ow;
      int         pv;

      dv[0] = D0; dv[1] = D1; dv[2] = D2; dv[3] = D3;
      in_bus = {D3, D2, D1, D0};
      n_rst  = 1'b0;
      n_req  = 4'b1111;
      lock   = 1'b0;

      // Reset state
      #23;
      for (int d = 0; d < 3; d++) push("reset", d, 4'b1111, 32'h0, 1'b0);
      drain();
      @(posedge clk);
      #1;
      n_rst = 1'b1;

      // Single request from ch2
      n_req = 4'b1011;
      for (int d = 0; d < 3; d++) push("single_gnt", d, 4'b1011, 32'h0, 1'b0);
      tick();
      for (int d = 0; d < 3; d++) push("single_data", d, 4'b1011, D2, 1'b1);
      tick();
      n_req = 4'b1111;
      for (int d = 0; d < 3; d++) push("release_edge", d, 4'b1111, D2, 1'b1);
      tick();
      push("turn_hold1", 0, 4'b1111, D2,    1'b0);
      push("turn_hold0", 1, 4'b1111, 32'h0, 1'b0);
      push("idle_tc0",   2, 4'b1111, D2,    1'b0);
      tick();

      // Reset in the middle of ch1 ownership
      n_req = 4'b1101;
      push("own1_main",  0, 4'b1101, D2,    1'b0);
      push("own1_hold0", 1, 4'b1101, 32'h0, 1'b0);
      push("own1_tc0",   2, 4'b1101, D2,    1'b0);
      tick();
      #2;
      n_rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) push("mid_rst", d, 4'b1111, 32'h0, 1'b0);
      drain();
      n_req = 4'b0000;
      #2;
      n_rst = 1'b1;
      for (int d = 0; d < 3; d++) push("post_rst_ch0", d, 4'b1110, 32'h0, 1'b0);
      tick();

      // All request, each owner holds two cycles: order 0,1,2,3,0
      for (int k = 0; k < 5; k++) begin
         ow = k % 4;
         ng = ~(4'b0001 << ow);
         if (k > 0) begin
            pv = (k - 1) % 4;
            push("rr_grant_main",  0, ng, dv[pv], 1'b0);
            push("rr_grant_hold0", 1, ng, 32'h0,  1'b0);
            tick();
         end
         push("rr_own_main",  0, ng, dv[ow], 1'b1);
         push("rr_own_hold0", 1, ng, dv[ow], 1'b1);
         tick();
         n_req[ow] = 1'b1;
         push("rr_gap_main",  0, 4'b1111, dv[ow], 1'b1);
         push("rr_gap_hold0", 1, 4'b1111, dv[ow], 1'b1);
         tick();
         if (k < 4) n_req[ow] = 1'b0;
      end
      n_req = 4'b1111;
      push("rr_end", 0, 4'b1111, D0, 1'b0);
      tick();
      tick();
      tick();

      // LOCK keeps ch1 on the bus after it drops its request
      n_req = 4'b1101;
      push("lock_gnt", 0, 4'b1101, D0, 1'b0);
      tick();
      lock  = 1'b1;
      n_req = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         push("lock_hold", 0, 4'b1101, D1, 1'b1);
         tick();
      end
      lock = 1'b0;
      push("lock_drop",     0, 4'b1111, D1, 1'b1);
      push("lock_drop_tc0", 2, 4'b0111, D1, 1'b1);
      tick();
      push("lock_next", 0, 4'b0111, D1, 1'b0);
      tick();
      push("lock_next_data", 0, 4'b0111, D3, 1'b1);
      tick();
      n_req = 4'b1111;
      tick();
      tick();
      tick();

      // Direct handover with TURN_CYCLES=0
      n_req = 4'b1110;
      push("tc0_gnt0", 2, 4'b1110, D3, 1'b0);
      tick();
      push("tc0_own0", 2, 4'b1110, D0, 1'b1);
      tick();
      n_req = 4'b0111;
      push("tc0_handover", 2, 4'b0111, D0, 1'b1);
      tick();
      push("tc0_own3", 2, 4'b0111, D3, 1'b1);
      tick();
      n_req = 4'b1111;
      push("tc0_release", 2, 4'b1111, D3, 1'b1);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
